hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32 core (IF, ID, EX, MEM, WB).
- Keeps a shadow scoreboard of in-flight destination registers per stage.
- Detects RAW hazards at ID and drives stall/bubble controls into the PC, IF_ID and ID_EX registers.
- Squashes wrong-path instructions when a taken branch/jump resolves in EX; keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.
- WB_HAZARD, 1, 1 = WB-stage writer counts as a hazard (regfile has no write-before-read); 0 = ignore WB slot.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- id_rs1  in  5  rs1 field of the IF_ID instruction.
- id_rs2  in  5  rs2 field of the IF_ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  5  rd field of the IF_ID instruction.
- id_regwen  in  1  ID instruction writes rd (controller RegWEn).
- id_is_load  in  1  ID instruction is a load (WBSel = DMEM).
- ex_redirect  in  1  PCSel_IDEX_out: taken branch/jump in EX this cycle.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF_ID keeps its contents.
- ifid_flush  out  1  IF_ID loads a NOP (0x00000013, controls zero).
- idex_bubble  out  1  ID_EX loads a NOP with RegWEn=0, MemRW=0, PCSel=0.
- stall_cnt  out  CNT_W  cycles with a hazard stall, saturating.
- flush_cnt  out  CNT_W  redirect events, saturating.

Behaviour:
- Shadow slots EX, MEM, WB each hold {valid, rd, we, ld}. Reset clears all slots and both counters; every output is 0 in the reset cycle.
- Slot advance every cycle:
  - EX <= (idex_bubble ? invalid : {1, id_rd, id_regwen, id_is_load}).
  - MEM <= EX; WB <= MEM.
- match(s, r): s.valid & s.we & (s.rd == r) & (r != 0). x0 never creates a hazard.
- hazard: (id_use_rs1 & M(id_rs1)) | (id_use_rs2 & M(id_rs2)).
  - M(r) = match(EX, r) | match(MEM, r) | (WB_HAZARD & match(WB, r)).
- Outputs are combinational from current slots and inputs (zero-latency decision).
- Priority 1, ex_redirect=1:
  - ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0.
  - Any hazard is ignored because the ID instruction is wrong-path.
  - flush_cnt += 1.
- Priority 2, hazard=1 and no redirect:
  - pc_hold=1, ifid_hold=1, idex_bubble=1, ifid_flush=0.
  - stall_cnt += 1.
- Otherwise all control outputs are 0.
- Stall duration without forwarding: producer in EX gives 3 stall cycles (WB_HAZARD=1) or 2 (WB_HAZARD=0). Stall releases the cycle after the producer leaves the last counted slot.
- Back-to-back redirects each flush and each increment flush_cnt.
- Counters saturate at all-ones and do not wrap.
- reset asserted mid-stall: the next cycle has all outputs 0 and empty slots. No pending stall survives reset.
- ifid_hold and ifid_flush are never both 1.

Optional Feature:
- Macro HAZARD_FWD_EN.
- When defined:
  - Adds outputs fwd_a_sel[1:0] and fwd_b_sel[1:0]: 00 = ID_EX register value, 01 = EX_MEM ALU result, 10 = MEM_WB write data.
  - EX slot additionally stores rs1/rs2/use flags.
  - Forward select compares the EX slot's rs1/rs2 against MEM (priority) then WB, using the same match rule.
  - Hazard narrows to load-use only: EX.ld & match(EX, r). This gives 1 stall cycle; the consumer then forwards from WB.
  - Forward selects reset to 00.
- When undefined: no fwd ports; full RAW stall as above.

Test Plan:
- Reset held 3 cycles, then released with idle inputs -> all outputs 0, counters 0.
- `addi x5` (rd=5, we=1) followed next cycle by `add` using rs1=5, WB_HAZARD=1, no FWD -> pc_hold/ifid_hold/idex_bubble high for exactly 3 cycles, stall_cnt=3.
- Producer with rd=0, we=1, consumer reads rs1=0 -> no stall, stall_cnt stays 0.
- Hazard stall active and ex_redirect=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_hold=0, flush_cnt=1, stall_cnt not incremented that cycle.
- HAZARD_FWD_EN: `lw x7` then `add` using x7 -> exactly 1 stall cycle, then fwd_a_sel=10. `add x8` then `sub` using x8 -> no stall, fwd_b_sel=01.
- Force stall_cnt to the 2^CNT_W-1 boundary with CNT_W=4: 16 stall cycles -> stall_cnt holds at 15. Assert reset mid-stall -> next cycle all outputs 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage operand/destination info in, pipeline stall/flush controls and counters out.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic id_use_rs1, id_use_rs2, id_regwen, id_is_load, ex_redirect;
  logic pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_sel, fwd_b_sel;
  modport master(output id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_regwen, id_is_load, ex_redirect,
                 input pc_hold, ifid_hold, ifid_flush, idex_bubble, stall_cnt, flush_cnt, fwd_a_sel, fwd_b_sel);
  modport slave(input id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_regwen, id_is_load, ex_redirect,
                output pc_hold, ifid_hold, ifid_flush, idex_bubble, stall_cnt, flush_cnt, fwd_a_sel, fwd_b_sel);
`else
  modport master(output id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_regwen, id_is_load, ex_redirect,
                 input pc_hold, ifid_hold, ifid_flush, idex_bubble, stall_cnt, flush_cnt);
  modport slave(input id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_regwen, id_is_load, ex_redirect,
                output pc_hold, ifid_hold, ifid_flush, idex_bubble, stall_cnt, flush_cnt);
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage RAW stall / redirect flush sequencer with saturating counters; HAZARD_FWD_EN adds forwarding selects.
module hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter bit WB_HAZARD = 1'b1
) (
  input logic clk,
  input logic reset,
  hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic v;
    logic [4:0] rd;
    logic we;
  } slot_t;
  slot_t ex, mem, wb;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic hit1, hit2, stall, redir;
  function automatic logic match(input slot_t s, input logic [4:0] r);
    return s.v && s.we && (s.rd == r) && (r != 5'd0);
  endfunction
`ifdef HAZARD_FWD_EN
  logic ex_ld, ex_u1, ex_u2;
  logic [4:0] ex_rs1, ex_rs2;
  function automatic logic [1:0] fsel(input logic u, input logic [4:0] r);
    return !(ex.v && u) ? 2'b00 : match(mem, r) ? 2'b01 : match(wb, r) ? 2'b10 : 2'b00;
  endfunction
  // Only a load still in EX cannot be forwarded in time
  assign hit1 = ex_ld && match(ex, bus.id_rs1);
  assign hit2 = ex_ld && match(ex, bus.id_rs2);
  assign bus.fwd_a_sel = reset ? 2'b00 : fsel(ex_u1, ex_rs1);
  assign bus.fwd_b_sel = reset ? 2'b00 : fsel(ex_u2, ex_rs2);
  always_ff @(posedge clk) begin
    if (reset) begin
      {ex_ld, ex_u1, ex_u2, ex_rs1, ex_rs2} <= '0;
    end else begin
      ex_ld <= !bus.idex_bubble && bus.id_is_load;
      ex_u1 <= !bus.idex_bubble && bus.id_use_rs1;
      ex_u2 <= !bus.idex_bubble && bus.id_use_rs2;
      ex_rs1 <= bus.id_rs1;
      ex_rs2 <= bus.id_rs2;
    end
  end
`else
  logic unused_ld;
  assign unused_ld = bus.id_is_load;
  assign hit1 = match(ex, bus.id_rs1) || match(mem, bus.id_rs1) || (WB_HAZARD && match(wb, bus.id_rs1));
  assign hit2 = match(ex, bus.id_rs2) || match(mem, bus.id_rs2) || (WB_HAZARD && match(wb, bus.id_rs2));
`endif
  // A redirect squashes the ID instruction, so its hazard is moot
  assign redir = bus.ex_redirect && !reset;
  assign stall = ((bus.id_use_rs1 && hit1) || (bus.id_use_rs2 && hit2)) && !bus.ex_redirect && !reset;
  assign bus.pc_hold = stall;
  assign bus.ifid_hold = stall;
  assign bus.ifid_flush = redir;
  assign bus.idex_bubble = stall || redir;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      ex <= bus.idex_bubble ? '0 : '{v: 1'b1, rd: bus.id_rd, we: bus.id_regwen};
      mem <= ex;
      wb <= mem;
      if (stall && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (redir && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall, x0, redirect priority, saturation and reset for hazard_ctrl (CNT_W=4).
module tb_hazard_ctrl;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int ST_ALU = FWD ? 0 : 3;
  localparam int ST_LD = FWD ? 1 : 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  hazard_ctrl_if #(.CNT_W(4)) bus ();
  hazard_ctrl #(.CNT_W(4), .WB_HAZARD(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic ctl(input string tag, input logic [3:0] exp);
    check(tag, {12'd0, bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble}, {12'd0, exp});
  endtask
  task automatic cnt(input string tag, input int s, input int f);
    check({tag, "_stall"}, {12'd0, bus.stall_cnt}, 16'(s));
    check({tag, "_flush"}, {12'd0, bus.flush_cnt}, 16'(f));
  endtask
  task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld, input logic rdir);
    bus.id_rs1 = rs1;
    bus.id_use_rs1 = u1;
    bus.id_rs2 = rs2;
    bus.id_use_rs2 = u2;
    bus.id_rd = rd;
    bus.id_regwen = we;
    bus.id_is_load = ld;
    bus.ex_redirect = rdir;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    drive(5'd1, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1);
    tick;
    ctl("rst_ctl", 4'b0000);
    tick;
    cnt("rst_cnt", 0, 0);
`ifdef HAZARD_FWD_EN
    check("rst_fwd", {12'd0, bus.fwd_a_sel, bus.fwd_b_sel}, 16'd0);
`endif
    tick;
    reset = 1'b0;
    idle;
    ctl("idle_ctl", 4'b0000);
    cnt("idle_cnt", 0, 0);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    ctl("x0_prod", 4'b0000);
    tick;
    drive(5'd0, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    ctl("x0_cons", 4'b0000);
    tick;
    idle;
    cnt("x0_cnt", 0, 0);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    ctl("alu_prod", 4'b0000);
    tick;
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < ST_ALU; i++) begin
      ctl("alu_stall", 4'b1101);
      tick;
    end
    ctl("alu_release", 4'b0000);
    exp_stall += ST_ALU;
    tick;
    idle;
    cnt("alu_cnt", exp_stall, 0);
    repeat (3) tick;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick;
    drive(5'd0, 1'b0, 5'd9, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    ctl("rdir_pre_stall", 4'b1101);
    exp_stall++;
    tick;
    drive(5'd0, 1'b0, 5'd9, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    ctl("rdir_over_stall", 4'b0011);
    tick;
    cnt("rdir_cnt1", exp_stall, 1);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    ctl("rdir_b2b", 4'b0011);
    tick;
    idle;
    ctl("rdir_after", 4'b0000);
    cnt("rdir_cnt2", exp_stall, 2);
    repeat (3) tick;
    for (int r = 0; r < 16; r++) begin
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
      tick;
      drive(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (ST_LD) tick;
    end
    idle;
    ctl("sat_release", 4'b0000);
    cnt("sat_cnt", 15, 2);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick;
    drive(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    ctl("mid_stall", 4'b1101);
    reset = 1'b1;
    #1;
    ctl("mid_rst_ctl", 4'b0000);
    tick;
    reset = 1'b0;
    #1;
    ctl("post_rst_ctl", 4'b0000);
    cnt("post_rst_cnt", 0, 0);
`ifdef HAZARD_FWD_EN
    idle;
    repeat (3) tick;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick;
    drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    ctl("lu_stall", 4'b1101);
    tick;
    ctl("lu_release", 4'b0000);
    tick;
    idle;
    check("lu_fwd_a", {14'd0, bus.fwd_a_sel}, 16'd2);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    tick;
    drive(5'd0, 1'b0, 5'd8, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    ctl("alu_fwd_nostall", 4'b0000);
    tick;
    idle;
    check("alu_fwd_b", {14'd0, bus.fwd_b_sel}, 16'd1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
